// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM state encoding, frame geometry and an address helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_CS
    } state_t;

    localparam int FRAME_W = 16;
    localparam int CMD_W   = 8;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;
    localparam int ADDR_W  = 7;

    // R/W position inside the command byte once it has been shifted in
    localparam int RW_CMD_BIT = RW_BIT - (FRAME_W - CMD_W);

    // True when a 7-bit frame address lands inside a register file of 'depth' entries
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/spi_slave_half_duplex_if.sv
// Pin/bus bundle between the half-duplex SPI slave and its environment.
// Latency: none (wiring only).
// Backpressure: none; SPI timing is set entirely by the master.
interface spi_slave_half_duplex_if;
    import spi_pkg::*;

    logic              sclk;
    logic              cs_n;
    logic              sdio_in;
    logic              sdio_out;
    logic              sdio_oe;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs_n, sdio_in,
        output sdio_out, sdio_oe, wr_valid, wr_addr, wr_data, frame_err, busy
    );

    modport master (
        output sclk, cs_n, sdio_in,
        input  sdio_out, sdio_oe, wr_valid, wr_addr, wr_data, frame_err, busy
    );

endinterface

// File: rtl/spi_slave_half_duplex_sync_edge.sv
// Multi-flop synchroniser, plus a variant that also flags rising/falling edges.
// Latency: STAGES clk to the synchronised level, edges flagged in the same clk the level changes.
// Backpressure: none; sampled continuously.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];
endmodule

module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic q;
    logic q_prev;

    spi_sync #(.STAGES(STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );

    // Remember the previous synchronised level for edge comparison.
    // Resetting to 0 means a chip select that is already low when reset
    // releases never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_prev <= 1'b0;
        end else begin
            q_prev <= q;
        end
    end

    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
endmodule

// File: rtl/spi_slave_half_duplex.sv
// SPI mode-0 half-duplex responder with a byte-wide register file, oversampled in clk.
// Latency: SYNC_STAGES+1 clk from a pin edge to the FSM reacting; wr_valid one clk after the last data bit is seen.
// Backpressure: none; the master paces frames and the slave must keep up (SCLK half-period >= 4 clk).
module spi_slave_half_duplex
    import spi_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_slave_half_duplex_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic sdio_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk path, so data and its sampling edge stay aligned
    spi_sync #(.STAGES(SYNC_STAGES)) u_sdio (
        .clk (clk),
        .rst (rst),
        .d   (bus.sdio_in),
        .q   (sdio_s)
    );

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [3:0]          rd_cnt;
    logic [CMD_W-2:0]    cmd_sh;
    logic [DATA_W-2:0]   data_sh;
    logic [DATA_W-1:0]   rd_sh;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic                sdio_out_r;
    logic                oe_r;
    logic                wr_valid_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                frame_err_r;
    logic                busy_r;

    logic [CMD_W-1:0]    cmd_next;
    logic [DATA_W-1:0]   data_next;

    assign cmd_next  = {cmd_sh, sdio_s};
    assign data_next = {data_sh, sdio_s};

    // Frame FSM, register file and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rd_cnt      <= '0;
            cmd_sh      <= '0;
            data_sh     <= '0;
            rd_sh       <= '0;
            addr_r      <= '0;
            sdio_out_r  <= 1'b0;
            oe_r        <= 1'b0;
            wr_valid_r  <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;

            if (cs_rise && (state == ST_CMD || state == ST_WDATA || state == ST_RDATA)) begin
                // Chip select lost mid-frame: drop everything, release the line
                state       <= ST_IDLE;
                busy_r      <= 1'b0;
                oe_r        <= 1'b0;
                sdio_out_r  <= 1'b0;
                frame_err_r <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            busy_r  <= 1'b1;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sh  <= cmd_next[CMD_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                addr_r <= cmd_next[ADDR_W-1:0];
                                if (cmd_next[RW_CMD_BIT]) begin
                                    state  <= ST_RDATA;
                                    rd_cnt <= '0;
                                    rd_sh  <= addr_in_range(cmd_next[ADDR_W-1:0], DEPTH)
                                              ? regs[cmd_next[IDX_W-1:0]] : '0;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (sclk_rise) begin
                            data_sh <= data_next[DATA_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_WAIT_CS;
                                if (addr_in_range(addr_r, DEPTH)) begin
                                    regs[addr_r[IDX_W-1:0]] <= data_next;
                                    wr_valid_r <= 1'b1;
                                    wr_addr_r  <= addr_r;
                                    wr_data_r  <= data_next;
                                end
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (sclk_fall) begin
                            if (rd_cnt < 4'd8) begin
                                oe_r       <= 1'b1;
                                sdio_out_r <= rd_sh[DATA_W-1];
                                rd_sh      <= {rd_sh[DATA_W-2:0], 1'b0};
                                rd_cnt     <= rd_cnt + 4'd1;
                            end else begin
                                // Bit 0 has been held through its rising edge: hand the line back
                                oe_r       <= 1'b0;
                                sdio_out_r <= 1'b0;
                                state      <= ST_WAIT_CS;
                            end
                        end
                    end

                    ST_WAIT_CS: begin
                        if (cs_rise) begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                        oe_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gate the enable with the abort edge so the line is released in the detecting clk
    assign bus.sdio_oe   = oe_r & ~cs_rise;
    assign bus.sdio_out  = sdio_out_r;
    assign bus.wr_valid  = wr_valid_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_half_duplex.sv
// Directed bench for the half-duplex SPI slave: writes, reads, range, abort, reset and back-to-back frames.
// Latency: SCLK half-period of HALF clk; outputs sampled on the falling clk edge.
// Backpressure: none; the bench acts as SPI master and pad model.
module tb_spi_slave_half_duplex;

    localparam int HALF = 8;

    logic clk;
    logic rst;
    logic m_oe;
    logic m_dat;
    logic [7:0] rd;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    int wr_cnt;
    int ferr_cnt;
    int oe_cyc;
    int oe_bad;
    logic [6:0] last_addr;
    logic [7:0] last_data;

    int s_wr, s_ferr, s_oe;

    spi_slave_half_duplex_if bus ();

    spi_slave_half_duplex #(.DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Shared SDIO pad: slave when enabled, else master, else weak pull-up
    assign bus.sdio_in = bus.sdio_oe ? bus.sdio_out : (m_oe ? m_dat : 1'b1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_cnt    = 0;
        ferr_cnt  = 0;
        oe_cyc    = 0;
        oe_bad    = 0;
        last_addr = '0;
        last_data = '0;
    end

    // Observe output pulses and line ownership away from the active edge
    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wr_cnt++;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
        end
        if (bus.frame_err) ferr_cnt++;
        if (bus.sdio_oe) oe_cyc++;
        if (bus.sdio_oe && bus.cs_n) oe_bad++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_wr   = wr_cnt;
        s_ferr = ferr_cnt;
        s_oe   = oe_cyc;
    endtask

    // One frame as SPI master; rst_at >= 0 pulses rst after that bit's falling edge
    task automatic frame(input logic [15:0] w, input int nbits, input int rst_at,
                         output logic [7:0] data);
        data = '0;
        m_oe = 1'b1;
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            m_dat = (i < 16) ? w[15-i] : 1'b0;
            m_oe  = !(w[15] && i >= 8);
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b1;
            if (i >= 8 && i < 16) data = {data[6:0], bus.sdio_in};
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
            if (i == rst_at) begin
                repeat (2) @(negedge clk);
                check("oe_before_rst", bus.sdio_oe, 1);
                rst = 1'b1;
                #1;
                check("oe_async_rst", bus.sdio_oe, 0);
                check("busy_async_rst", bus.busy, 0);
            end
            if (rst_at >= 0 && i == rst_at + 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
        end
        m_oe = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus.sclk  = 1'b0;
        bus.cs_n  = 1'b1;
        m_oe      = 1'b1;
        m_dat     = 1'b0;
        rd        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sdio_out", bus.sdio_out, 0);
        check("rst_sdio_oe", bus.sdio_oe, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0x05 <= 0xA5
        snap();
        frame(16'h05A5, 16, -1, rd);
        check("wr1_count", wr_cnt - s_wr, 1);
        check("wr1_addr", last_addr, 7'h05);
        check("wr1_data", last_data, 8'hA5);
        check("wr1_oe_cycles", oe_cyc - s_oe, 0);
        check("wr1_ferr", ferr_cnt - s_ferr, 0);
        check("wr1_busy_after", bus.busy, 0);

        // Read back 0x05
        snap();
        frame(16'h8500, 16, -1, rd);
        check("rd1_data", rd, 8'hA5);
        check("rd1_oe_cycles", oe_cyc - s_oe, 128);
        check("rd1_ferr", ferr_cnt - s_ferr, 0);
        check("rd1_no_write", wr_cnt - s_wr, 0);

        // Out-of-range write, then read it and the aliased low address
        snap();
        frame(16'h23A2, 16, -1, rd);
        check("oor_no_write", wr_cnt - s_wr, 0);
        check("oor_ferr", ferr_cnt - s_ferr, 0);
        frame(16'hA300, 16, -1, rd);
        check("oor_read_zero", rd, 8'h00);
        frame(16'h8300, 16, -1, rd);
        check("reg03_unchanged", rd, 8'h00);

        // Abort a write after 11 bits
        snap();
        frame(16'h0712, 11, -1, rd);
        check("abort_ferr", ferr_cnt - s_ferr, 1);
        check("abort_no_write", wr_cnt - s_wr, 0);
        check("abort_busy", bus.busy, 0);
        frame(16'h8700, 16, -1, rd);
        check("abort_reg07", rd, 8'h00);

        // Extra SCLK pulses after a complete write are ignored
        snap();
        frame(16'h0B55, 18, -1, rd);
        check("extra_write", wr_cnt - s_wr, 1);
        check("extra_data", last_data, 8'h55);
        check("extra_ferr", ferr_cnt - s_ferr, 0);

        // Reset in the middle of a read of 0x05; remainder of that frame must be ignored
        snap();
        frame(16'h8500, 16, 10, rd);
        check("rstmid_ferr", ferr_cnt - s_ferr, 0);
        check("rstmid_no_write", wr_cnt - s_wr, 0);
        check("rstmid_busy", bus.busy, 0);
        frame(16'h8500, 16, -1, rd);
        check("rstmid_reg05", rd, 8'h00);
        frame(16'h8B00, 16, -1, rd);
        check("rstmid_reg0b", rd, 8'h00);

        // Back-to-back write then read of 0x0A
        snap();
        frame(16'h0A3C, 16, -1, rd);
        frame(16'h8A00, 16, -1, rd);
        check("b2b_read", rd, 8'h3C);
        check("b2b_write", wr_cnt - s_wr, 1);
        check("b2b_addr", last_addr, 7'h0A);

        check("oe_while_cs_high", oe_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave_half_duplex.md
Name: spi_slave_half_duplex

Overview:
- SPI mode-0 responder for the half-duplex link; the counterpart to the existing SPI master.
- Owns one shared serial data line (SDIO) through an in/out/output-enable triple and holds a small byte-wide register file.
- Write frames are 16 bits inbound. Read frames are 8 bits inbound followed by 8 bits outbound, with a line turnaround in between.
- Runs entirely in the system `clk` domain; `sclk`, `cs_n` and `sdio_in` are oversampled.

Parameters:
- DEPTH, 16, number of 8-bit registers (power of two, 2..128)
- SYNC_STAGES, 2, synchroniser flops on `sclk`, `cs_n` and `sdio_in`

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-high reset
- sclk  input  1  SPI clock from master; idles low (mode 0)
- cs_n  input  1  chip select, active low
- sdio_in  input  1  SDIO as seen at the pad
- sdio_out  output  1  SDIO drive value
- sdio_oe  output  1  1 = slave drives SDIO
- wr_valid  output  1  one-clk pulse when a register write commits
- wr_addr  output  7  address of the committed write
- wr_data  output  8  data of the committed write
- frame_err  output  1  one-clk pulse on an aborted or short frame
- busy  output  1  high while a frame is in progress

Behaviour:
- Reset: all outputs are 0; the register file is all 0x00; FSM is in IDLE.
- Reset is asynchronous, active-high.
- Synchronisation and edge detection:
  - `sclk`, `cs_n` and `sdio_in` each pass through SYNC_STAGES flops.
  - Rising and falling `sclk` edges and falling/rising `cs_n` edges are detected on the synchronised signals.
  - Requirement: SCLK half-period ≥ 4 clk periods.
- Frame format (MSB first):
  - bit 15 = R/W (1 = read)
  - bits 14:8 = address
  - bits 7:0 = write data, or read data driven by the slave
- Sampling: inbound bits are sampled on synchronised `sclk` rising edges. The slave changes `sdio_out` on falling edges.
- FSM states: IDLE, CMD, WDATA, RDATA, WAIT_CS.
  - IDLE → CMD on `cs_n` falling; bit counter cleared; `busy` = 1.
  - CMD: shift in 8 bits. After the 8th rising edge:
    - R/W = 0 → WDATA.
    - R/W = 1 → RDATA.
  - WDATA: shift in 8 bits. On the 8th rising edge:
    - Address < DEPTH: write the register; pulse `wr_valid` with `wr_addr`/`wr_data` one clk later.
    - Address ≥ DEPTH: write ignored; no `wr_valid`.
    - Then → WAIT_CS.
  - RDATA:
    - Load the read byte at CMD completion; out-of-range addresses read 0x00.
    - On the next `sclk` falling edge, assert `sdio_oe` and drive bit 7.
    - Each following falling edge drives the next bit.
    - After bit 0 has been held through its rising edge, the next falling edge deasserts `sdio_oe` → WAIT_CS.
  - WAIT_CS: ignore `sclk`. On `cs_n` rising → IDLE; `busy` = 0.
- Abort: `cs_n` rising in CMD, WDATA or RDATA means:
  - no register write;
  - `sdio_oe` = 0 in the same clk the edge is detected;
  - `frame_err` pulses;
  - → IDLE.
- Extra clocks: additional `sclk` edges in WAIT_CS are ignored, with no error.
- `sdio_oe` is never high outside RDATA, so there is no contention window with the master.
- Register write then read of the same address in consecutive frames returns the new value.
- `rst` asserted mid-frame: immediate return to reset state and register file cleared. The frame after `rst` deasserts is accepted only from a fresh `cs_n` falling edge; if `cs_n` is already low, wait for `cs_n` high first.

Decomposition:
- Shared package `spi_pkg`:
  - state encoding (IDLE, CMD, WDATA, RDATA, WAIT_CS);
  - constants FRAME_W = 16, CMD_W = 8, DATA_W = 8, RW_BIT = 15, ADDR_W = 7.
  - The master uses the same package.
- One sub-module, `spi_sync_edge`: synchroniser plus rise/fall detector, instantiated for `sclk` and `cs_n` (the synchroniser alone is reused for `sdio_in`).

Test Plan:
- Write: frame 0x05A5 → `wr_valid` pulse once, `wr_addr` = 0x05, `wr_data` = 0xA5; `sdio_oe` stays 0 throughout.
- Read back: command 0x85 then 8 clocks → slave drives 0xA5 MSB first, `sdio_oe` high only for those 8 bit periods; `frame_err` = 0.
- Out-of-range: frame 0x23A2 (addr 0x23 ≥ 16) → no `wr_valid`; a following read 0xA3 returns 0x00; register 0x03 is unchanged.
- Abort: raise `cs_n` after 11 bits of write frame 0x0712 → `frame_err` pulse, no write, reg 0x07 still 0x00, `busy` = 0.
- Reset mid-read: read of 0x05 (holding 0xA5), `rst` asserted after the 3rd data bit → `sdio_oe` = 0 asynchronously; reg 0x05 reads 0x00 on the next full frame.
- Back-to-back: write 0x0A3C, `cs_n` high for 2 SCLK periods, read 0x8A → returns 0x3C.
